// File: rtl/shift_add_mul.sv
// ============================================================================
//  Module   : shift_add_mul
//  Brief    : Iterative shift-and-add multiplier, one partial product per
//             cycle through a single W+1-bit add path, valid/ready on both
//             sides. Define SHIFT_ADD_MUL_SIGNED_EN for two's-complement
//             operands (sign-extended addend, arithmetic shift, final-step
//             subtract).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mul #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

    localparam int            CW     = $clog2(W + 1);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     r_acc;
    logic [W-1:0]   r_mreg;
    logic [W-1:0]   r_areg;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic           w_last;
    logic [W:0]     w_acc_nxt;
    logic [W-1:0]   w_mreg_nxt;

    assign w_last = (r_cnt == C_LAST);

`ifdef SHIFT_ADD_MUL_SIGNED_EN
    logic [W:0]     w_ext;
    logic [W:0]     w_addend;
    logic [W:0]     w_sum;
    logic           w_sub;

    // The multiplier MSB carries weight -2^(W-1), so its step subtracts.
    assign w_ext      = {r_areg[W-1], r_areg};
    assign w_sub      = w_last & r_mreg[0];
    assign w_addend   = w_sub ? ~w_ext : (r_mreg[0] ? w_ext : '0);
    assign w_sum      = r_acc + w_addend + {{W{1'b0}}, w_sub};
    assign w_acc_nxt  = {w_sum[W], w_sum[W:1]};
    assign w_mreg_nxt = {w_sum[0], r_mreg[W-1:1]};
`else
    logic [W:0]     w_addend;
    logic [W+1:0]   w_sum;

    assign w_addend   = r_mreg[0] ? {1'b0, r_areg} : '0;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_acc_nxt  = w_sum[W+1:1];
    assign w_mreg_nxt = {w_sum[0], r_mreg[W-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mreg      <= '0;
            r_areg      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_areg     <= a;
                        r_mreg     <= b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_nxt;
                    r_mreg <= w_mreg_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_out_valid ? {r_acc[W-1:0], r_mreg} : '0;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mul.sv
// ============================================================================
//  Module   : tb_shift_add_mul
//  Brief    : Self-checking bench for shift_add_mul (directed + random ops).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mul;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   p;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_add_mul #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product straight from integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint vx;
        longint vy;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        vx = longint'($signed(x));
        vy = longint'($signed(y));
`else
        vx = longint'(x);
        vy = longint'(y);
`endif
        return (2*W)'(vx * vy);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; optional back-pressure hold and busy-time pulse.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, input bit pulse);
        logic [2*W-1:0] held;
        int n;
        check("ready_before_accept", 64'(in_ready), 64'd1);
        a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_in_run", 64'({busy, in_ready, out_valid}), 64'b100);
        n = 0;
        while (!out_valid && n < 100) begin
            if (pulse && n == 2) begin
                a = 5; b = 5; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            n++;
        end
        check("latency_edges", 64'(n), 64'(W));
        check("product", 64'(p), 64'(model(x, y)));
        held = p;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("held_state", 64'({out_valid, in_ready, busy}), 64'b101);
            check("held_p", 64'(p), 64'(held));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("back_to_idle", 64'({out_valid, in_ready, busy}), 64'b010);
        check("p_gated", 64'(p), 64'd0);
    endtask

    task automatic expect_quiet(input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("no_extra_valid", 64'(seen), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick();
        rst = 1'b0;
        check("reset_state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset_p", 64'(p), 64'd0);

        do_op(8'd255, 8'd255, 0, 1'b0);
        do_op(8'd13, 8'd11, 0, 1'b0);
        do_op(8'd200, 8'd3, 5, 1'b0);
        do_op(8'd0, 8'd77, 0, 1'b1);
        expect_quiet(W + 3);

        // Abort on the 4th RUN edge.
        a = 9; b = 9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("abort_p", 64'(p), 64'd0);
        expect_quiet(W + 3);
        do_op(8'd9, 8'd9, 0, 1'b0);

        // Reset beats a simultaneous request.
        rst = 1'b1; in_valid = 1'b1; a = 3; b = 3;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_wins", 64'({in_ready, out_valid, busy}), 64'b100);
        expect_quiet(W + 2);

`ifdef SHIFT_ADD_MUL_SIGNED_EN
        do_op(8'h80, 8'h80, 0, 1'b0);
        do_op(8'hFF, 8'h01, 0, 1'b0);
        do_op(8'd127, 8'hFE, 0, 1'b0);
`endif

        for (int k = 0; k < 12; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
